// File: rtl/dac_fp_tx_if.sv
// Command/status and serial-link signals of the 16Q48-to-DAC output path.
// The transmitter takes the slave view; whoever issues commands takes the master view.
interface dac_fp_tx_if #(
  parameter int FP_WIDTH  = 64,
  parameter int CMD_WIDTH = 4,
  parameter int DAC_WIDTH = 12
) ();
  logic signed [FP_WIDTH-1:0] DAC_FP_IN;
  logic [CMD_WIDTH-1:0]       DAC_CMD;
  logic                       DAC_START;
  logic                       DAC_BUSY;
  logic                       DAC_DONE;
  logic                       DAC_SAT;
  logic [DAC_WIDTH-1:0]       DAC_CODE_OUT;
  logic                       DAC_SYNC_N;
  logic                       DAC_SCLK;
  logic                       DAC_SDI;

  modport master (
    output DAC_FP_IN, DAC_CMD, DAC_START,
    input  DAC_BUSY, DAC_DONE, DAC_SAT, DAC_CODE_OUT, DAC_SYNC_N, DAC_SCLK, DAC_SDI
  );

  modport slave (
    input  DAC_FP_IN, DAC_CMD, DAC_START,
    output DAC_BUSY, DAC_DONE, DAC_SAT, DAC_CODE_OUT, DAC_SYNC_N, DAC_SCLK, DAC_SDI
  );
endinterface

// File: rtl/dac_fp_tx.sv
// Converts a signed 16Q48 actuator command to a saturated DAC code and ships {cmd, code}
// MSB first over a SYNC_N/SCLK/SDI link; one frame per accepted start request.
module dac_fp_tx #(
  parameter int FP_WIDTH  = 64,
  parameter int FRAC_BITS = 48,
  parameter int DAC_WIDTH = 12,
  parameter int CMD_WIDTH = 4,
  parameter int CLK_DIV   = 4,
  parameter int SYNC_GAP  = 2
) (
  input  logic       DAC_CLK,
  input  logic       DAC_RST,
  dac_fp_tx_if.slave dac
);
  localparam int FRAME_BITS = CMD_WIDTH + DAC_WIDTH;
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int DIV_W      = $clog2(CLK_DIV + 1);
  localparam int GAP_W      = $clog2(SYNC_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHIFT, S_GAP} state_e;

  function automatic logic [DAC_WIDTH:0] round_half_up(input logic signed [FP_WIDTH-1:0] x);
    logic [DAC_WIDTH:0] sum;
    sum = {1'b0, x[FRAC_BITS-1 -: DAC_WIDTH]}
        + {{DAC_WIDTH{1'b0}}, x[FRAC_BITS-DAC_WIDTH-1]};
    return sum;
  endfunction

  // Result is {sat, code}; a rounding carry clamps without flagging saturation.
  function automatic logic [DAC_WIDTH:0] saturate(input logic signed [FP_WIDTH-1:0] x,
                                                  input logic [DAC_WIDTH:0]       rounded);
    logic [DAC_WIDTH:0] res;
    if (x[FP_WIDTH-1])
      res = {1'b1, {DAC_WIDTH{1'b0}}};
    else if (|x[FP_WIDTH-2:FRAC_BITS])
      res = {1'b1, {DAC_WIDTH{1'b1}}};
    else if (rounded[DAC_WIDTH])
      res = {1'b0, {DAC_WIDTH{1'b1}}};
    else
      res = {1'b0, rounded[DAC_WIDTH-1:0]};
    return res;
  endfunction

  state_e                     state_q, state_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       sat_q, sat_d;
  logic [DAC_WIDTH-1:0]       code_q, code_d;
  logic                       sync_n_q, sync_n_d;
  logic                       sclk_q, sclk_d;
  logic                       sdi_q, sdi_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [GAP_W-1:0]           gap_q, gap_d;

  logic signed [FP_WIDTH-1:0] x_q;
  logic [CMD_WIDTH-1:0]       cmd_q;
  logic [FRAME_BITS-1:0]      sreg_q;

  logic                       capture, load, shift;
  logic [DAC_WIDTH:0]         rounded;
  logic [DAC_WIDTH:0]         conv_res;
  logic [FRAME_BITS-1:0]      frame_w;

  assign rounded  = round_half_up(x_q);
  assign conv_res = saturate(x_q, rounded);
  assign frame_w  = {cmd_q, conv_res[DAC_WIDTH-1:0]};

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sat_d    = sat_q;
    code_d   = code_q;
    sync_n_d = sync_n_q;
    sclk_d   = sclk_q;
    sdi_d    = sdi_q;
    bit_d    = bit_q;
    div_d    = div_q;
    gap_d    = gap_q;
    capture  = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = dac.DAC_START;
        if (dac.DAC_START) begin
          capture = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        sat_d    = conv_res[DAC_WIDTH];
        code_d   = conv_res[DAC_WIDTH-1:0];
        load     = 1'b1;
        sync_n_d = 1'b0;
        sclk_d   = 1'b1;
        sdi_d    = frame_w[FRAME_BITS-1];
        bit_d    = '0;
        div_d    = '0;
        state_d  = S_SHIFT;
      end
      // SDI only moves together with a rising SCLK, so it is stable across the DAC's falling-edge sample.
      S_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == BIT_LAST) begin
            sclk_d   = 1'b1;
            sync_n_d = 1'b1;
            sdi_d    = 1'b0;
            gap_d    = '0;
            state_d  = S_GAP;
          end else begin
            sclk_d = 1'b1;
            sdi_d  = sreg_q[FRAME_BITS-2];
            shift  = 1'b1;
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge DAC_CLK) begin
    if (DAC_RST) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      code_q   <= '0;
      sync_n_q <= 1'b1;
      sclk_q   <= 1'b1;
      sdi_q    <= 1'b0;
      bit_q    <= '0;
      div_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
      code_q   <= code_d;
      sync_n_q <= sync_n_d;
      sclk_q   <= sclk_d;
      sdi_q    <= sdi_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
    end
  end

  // Captured operands and the frame shifter carry no reset; they are always reloaded before use.
  always_ff @(posedge DAC_CLK) begin
    if (capture) begin
      x_q   <= dac.DAC_FP_IN;
      cmd_q <= dac.DAC_CMD;
    end
    if (load)
      sreg_q <= frame_w;
    else if (shift)
      sreg_q <= sreg_q << 1;
  end

  assign dac.DAC_BUSY     = busy_q;
  assign dac.DAC_DONE     = done_q;
  assign dac.DAC_SAT      = sat_q;
  assign dac.DAC_CODE_OUT = code_q;
  assign dac.DAC_SYNC_N   = sync_n_q;
  assign dac.DAC_SCLK     = sclk_q;
  assign dac.DAC_SDI      = sdi_q;
endmodule

// File: tb/tb_dac_fp_tx.sv
// Bench for dac_fp_tx: table-driven conversions, directed start/reset sequences, and
// randomized frames on extra clock-divider/gap configurations, all checked by SPI word scoreboards.
module tb_dac_fp_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [12:0] model(input logic [63:0] x);
    longint signed v;
    longint signed r;
    v = signed'(x);
    if (v < 0) return 13'h1000;
    if (v >= 64'sh0001_0000_0000_0000) return 13'h1FFF;
    r = (v + 64'sh0000_0008_0000_0000) >>> 36;
    if (r > 4095) r = 4095;
    return {1'b0, r[11:0]};
  endfunction

  dac_fp_tx_if #(.FP_WIDTH(64), .CMD_WIDTH(4), .DAC_WIDTH(12)) bus ();
  dac_fp_tx #(.CLK_DIV(4), .SYNC_GAP(2)) u_dut (.DAC_CLK(clk), .DAC_RST(rst), .dac(bus));

  // Main-instance SPI monitor and scoreboard
  logic [15:0] mq[$];
  logic [15:0] sh = '0;
  int   nb = 0, since_fall = 0, per_err = 0, glitch = 0, partial = 0;
  logic p_sclk = 1'b1, p_sync = 1'b1, p_sdi = 1'b0;

  always @(negedge clk) begin
    since_fall++;
    if (!bus.DAC_SYNC_N) begin
      if (p_sync) nb = 0;
      if (p_sclk && !bus.DAC_SCLK) begin
        sh = {sh[14:0], bus.DAC_SDI};
        nb++;
        if (nb > 1 && since_fall != 8) per_err++;
        since_fall = 0;
      end
      if (!p_sync && (bus.DAC_SDI != p_sdi) && !(!p_sclk && bus.DAC_SCLK)) glitch++;
    end else if (!p_sync) begin
      if (nb == 16) begin
        if (mq.size() == 0) check("spi_queue_size", 64'(mq.size()), 64'd1);
        else check("spi_word", sh, mq.pop_front());
      end else begin
        partial++;
      end
      nb = 0;
    end
    p_sclk = bus.DAC_SCLK;
    p_sync = bus.DAC_SYNC_N;
    p_sdi  = bus.DAC_SDI;
  end

  task automatic run_frame(input logic [63:0] x, input logic [3:0] c,
                           input logic [11:0] ecode, input logic esat);
    int lat;
    @(negedge clk);
    bus.DAC_FP_IN = x;
    bus.DAC_CMD   = c;
    bus.DAC_START = 1'b1;
    mq.push_back({c, ecode});
    @(posedge clk);
    #1;
    bus.DAC_START = 1'b0;
    bus.DAC_FP_IN = ~x;
    bus.DAC_CMD   = ~c;
    lat = 0;
    while (!bus.DAC_DONE && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd132);
    check("code_out", bus.DAC_CODE_OUT, ecode);
    check("sat", bus.DAC_SAT, esat);
  endtask

  typedef struct {
    logic [63:0] x;
    logic [3:0]  cmd;
    logic [11:0] code;
    logic        sat;
  } vec_t;
  vec_t vecs[10];

  // Extra configurations with randomized frames
  for (genvar g = 0; g < 2; g++) begin : G_CFG
    localparam int CD = (g == 0) ? 1 : 4;
    localparam int SG = (g == 0) ? 1 : 3;
    logic rst_g = 1'b1;
    logic fin = 1'b0;
    dac_fp_tx_if #(.FP_WIDTH(64), .CMD_WIDTH(4), .DAC_WIDTH(12)) bus_g ();
    dac_fp_tx #(.CLK_DIV(CD), .SYNC_GAP(SG)) u_dut_g (.DAC_CLK(clk), .DAC_RST(rst_g), .dac(bus_g));

    logic [15:0] q[$];
    logic [15:0] shg = '0;
    int   nbg = 0, since = 0, perr = 0;
    logic ps = 1'b1, py = 1'b1;

    always @(negedge clk) begin
      since++;
      if (!bus_g.DAC_SYNC_N) begin
        if (py) nbg = 0;
        if (ps && !bus_g.DAC_SCLK) begin
          shg = {shg[14:0], bus_g.DAC_SDI};
          nbg++;
          if (nbg > 1 && since != 2 * CD) perr++;
          since = 0;
        end
      end else if (!py) begin
        if (q.size() == 0) check("g_queue_size", 64'(q.size()), 64'd1);
        else check("g_spi_word", {nbg[7:0], shg}, {8'd16, q.pop_front()});
        nbg = 0;
      end
      ps = bus_g.DAC_SCLK;
      py = bus_g.DAC_SYNC_N;
    end

    initial begin
      logic [63:0] x;
      logic [3:0]  c;
      logic [12:0] m;
      int          lat;
      bus_g.DAC_START = 1'b0;
      bus_g.DAC_FP_IN = '0;
      bus_g.DAC_CMD   = '0;
      repeat (3) @(posedge clk);
      #1 rst_g = 1'b0;
      for (int i = 0; i < 6; i++) begin
        x = {$urandom, $urandom};
        if (i % 3 == 0) x[63:48] = 16'h0000;
        c = 4'($urandom_range(0, 15));
        m = model(x);
        @(negedge clk);
        bus_g.DAC_FP_IN = x;
        bus_g.DAC_CMD   = c;
        bus_g.DAC_START = 1'b1;
        q.push_back({c, m[11:0]});
        @(posedge clk);
        #1;
        bus_g.DAC_START = 1'b0;
        bus_g.DAC_FP_IN = ~x;
        lat = 0;
        while (!bus_g.DAC_DONE && lat < 1000) begin
          @(posedge clk);
          #1;
          lat++;
        end
        check("g_latency", 64'(lat), 64'(2 + 32 * CD + SG));
        check("g_code_out", bus_g.DAC_CODE_OUT, m[11:0]);
        check("g_sat", bus_g.DAC_SAT, m[12]);
      end
      repeat (5) @(posedge clk);
      #1;
      check("g_sclk_period", 64'(perr), 64'd0);
      check("g_queue_drained", 64'(q.size()), 64'd0);
      fin = 1'b1;
    end
  end

  initial begin
    int d1, d2, dones, k;
    vecs[0] = '{64'h0000_8000_0000_0000, 4'h3, 12'h800, 1'b0};
    vecs[1] = '{64'hFFFF_0000_0000_0000, 4'h5, 12'h000, 1'b1};
    vecs[2] = '{64'h0001_0000_0000_0000, 4'hA, 12'hFFF, 1'b1};
    vecs[3] = '{64'h0000_FFFF_FFFF_FFFF, 4'h1, 12'hFFF, 1'b0};
    vecs[4] = '{64'h0000_0008_0000_0000, 4'hF, 12'h001, 1'b0};
    vecs[5] = '{64'h0000_0007_FFFF_FFFF, 4'h0, 12'h000, 1'b0};
    vecs[6] = '{64'h0000_7FFF_FFFF_FFFF, 4'h6, 12'h800, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 4'h2, 12'h000, 1'b1};
    vecs[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 4'h9, 12'hFFF, 1'b1};
    vecs[9] = '{64'h0000_0000_0000_0000, 4'h0, 12'h000, 1'b0};

    bus.DAC_START = 1'b0;
    bus.DAC_FP_IN = '0;
    bus.DAC_CMD   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sync_n", bus.DAC_SYNC_N, 1'b1);
    check("rst_sclk", bus.DAC_SCLK, 1'b1);
    check("rst_sdi", bus.DAC_SDI, 1'b0);
    check("rst_busy", bus.DAC_BUSY, 1'b0);
    check("rst_done", bus.DAC_DONE, 1'b0);
    check("rst_sat", bus.DAC_SAT, 1'b0);
    check("rst_code", bus.DAC_CODE_OUT, 12'h000);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_frame(vecs[i].x, vecs[i].cmd, vecs[i].code, vecs[i].sat);

    // START held high across the whole first frame: second frame begins right after DONE
    @(negedge clk);
    bus.DAC_FP_IN = 64'h0000_4000_0000_0000;
    bus.DAC_CMD   = 4'hC;
    bus.DAC_START = 1'b1;
    mq.push_back(16'hC400);
    mq.push_back(16'hC400);
    d1 = -1;
    d2 = -1;
    for (int n = 0; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) check("t4_busy_after_start", bus.DAC_BUSY, 1'b1);
      if (bus.DAC_DONE) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (n == 140) bus.DAC_START = 1'b0;
    end
    check("t4_first_done", 64'(d1), 64'd132);
    check("t4_second_done", 64'(d2), 64'd265);

    // Reset in the middle of SHIFT abandons the frame
    @(negedge clk);
    bus.DAC_FP_IN = 64'h0000_4000_0000_0000;
    bus.DAC_CMD   = 4'h7;
    bus.DAC_START = 1'b1;
    @(posedge clk);
    #1 bus.DAC_START = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5_sync_n", bus.DAC_SYNC_N, 1'b1);
    check("t5_sclk", bus.DAC_SCLK, 1'b1);
    check("t5_sdi", bus.DAC_SDI, 1'b0);
    check("t5_busy", bus.DAC_BUSY, 1'b0);
    check("t5_code", bus.DAC_CODE_OUT, 12'h000);
    check("t5_sat", bus.DAC_SAT, 1'b0);
    dones = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (bus.DAC_DONE) dones++;
    end
    check("t5_no_done", 64'(dones), 64'd0);
    run_frame(64'h0000_C000_0000_0000, 4'h4, 12'hC00, 1'b0);

    k = 0;
    while (!(G_CFG[0].fin && G_CFG[1].fin) && k < 20000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("gen_finished", {G_CFG[0].fin, G_CFG[1].fin}, 2'b11);
    check("sclk_period", 64'(per_err), 64'd0);
    check("sdi_glitch", 64'(glitch), 64'd0);
    check("partial_frames", 64'(partial), 64'd1);
    check("queue_drained", 64'(mq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
